// File: rtl/data_sram_responder.sv
// Slave end of the core's sram-like data interface: word-organised memory
// with byte write enables, one-cycle read latency, sticky out-of-range
// capture and saturating read/write access counters.
module data_sram_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             addr_err,
    output logic [31:0]      err_addr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  rd_req;
    logic                  wr_req;
    logic                  bad_req;
    logic                  mem_we;
    logic [31:0]           merged_word;
    logic                  unused_addr_lsbs;

    logic [31:0]      rdata_d,    rdata_q;
    logic             addr_err_d, addr_err_q;
    logic [31:0]      err_addr_d, err_addr_q;
    logic [CNT_W-1:0] rd_cnt_d,   rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_d,   wr_cnt_q;

    // Byte offset is irrelevant to a word-organised memory.
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    assign idx      = data_sram_addr[DEPTH_LOG2+1:2];
    assign in_range = (data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign rd_req   = data_sram_en &&  in_range && (data_sram_wen == 4'b0000);
    assign wr_req   = data_sram_en &&  in_range && (data_sram_wen != 4'b0000);
    assign bad_req  = data_sram_en && !in_range;
    // A request seen while reset is held must not touch memory.
    assign mem_we   = wr_req && rst;

    // Merge enabled write lanes over the stored word; equals the stored word on reads.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        merged_word = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) begin
                merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Storage array update on in-range writes.
    // NOTE: the memory has no reset; its contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merged_word;
        end
    end

    // Next-state for read data, error capture and saturating counters.
    always_comb begin
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        err_addr_d = err_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        if (bad_req) begin
            rdata_d = 32'h0;
        end else if (rd_req || wr_req) begin
            rdata_d = merged_word;
        end

        if (bad_req) begin
            addr_err_d = 1'b1;
            // First error wins, unless this edge also clears the old one.
            if (!addr_err_q || err_clr) begin
                err_addr_d = data_sram_addr;
            end
        end else if (err_clr) begin
            addr_err_d = 1'b0;
            err_addr_d = 32'h0;
        end

        if (rd_req && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
        if (wr_req && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    // Output and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
            err_addr_q <= 32'h0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
            err_addr_q <= err_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign addr_err        = addr_err_q;
    assign err_addr        = err_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios plus a
// randomized run, all compared against a byte-addressed behavioural model.
module tb_data_sram_responder;

    localparam int          DEPTH_LOG2 = 14;
    localparam int          CNT_W      = 4;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam longint      WINDOW     = 4 * (longint'(1) << DEPTH_LOG2);
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             data_sram_en;
    logic [3:0]       data_sram_wen;
    logic [31:0]      data_sram_addr;
    logic [31:0]      data_sram_wdata;
    logic [31:0]      data_sram_rdata;
    logic             addr_err;
    logic [31:0]      err_addr;
    logic             err_clr;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory as individual bytes keyed by byte address.
    bit [7:0]    mem_b [bit [31:0]];
    logic [31:0] exp_rdata;
    bit          exp_known;
    bit          exp_err;
    logic [31:0] exp_err_addr;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] pool [8];

    data_sram_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .BASE_ADDR (BASE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .addr_err       (addr_err),
        .err_addr       (err_addr),
        .err_clr        (err_clr),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_in_range(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + WINDOW);
    endfunction

    function automatic void model_reset();
        exp_rdata    = 32'h0;
        exp_known    = 1'b1;
        exp_err      = 1'b0;
        exp_err_addr = 32'h0;
        exp_rd       = 0;
        exp_wr       = 0;
    endfunction

    function automatic void model_step(input bit en, input logic [3:0] wen,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input bit clr);
        bit          inr;
        logic [31:0] word_base;
        inr = model_in_range(addr);
        if (en && !inr) begin
            if (!exp_err || clr) exp_err_addr = addr;
            exp_err = 1'b1;
        end else if (clr) begin
            exp_err      = 1'b0;
            exp_err_addr = 32'h0;
        end
        if (!en) return;
        if (!inr) begin
            exp_rdata = 32'h0;
            exp_known = 1'b1;
            return;
        end
        word_base = addr & 32'hFFFF_FFFC;
        if (wen != 4'b0000) begin
            for (int i = 0; i < 4; i++)
                if (wen[i]) mem_b[word_base + 32'(i)] = wdata[8*i +: 8];
            if (exp_wr < CNT_MAX) exp_wr++;
        end else begin
            if (exp_rd < CNT_MAX) exp_rd++;
        end
        exp_known = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mem_b.exists(word_base + 32'(i))) exp_rdata[8*i +: 8] = mem_b[word_base + 32'(i)];
            else exp_known = 1'b0;
        end
    endfunction

    // Apply one request across one rising edge, then settle 1 time unit past it.
    task automatic drive_cycle(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit clr);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        err_clr         = clr;
        @(posedge clk);
        if (rst) model_step(en, wen, addr, wdata, clr);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0000_0010;
        data_sram_wdata = 32'h0;
        err_clr         = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", data_sram_rdata, 32'h0); end
            checks++;
            if (rd_cnt !== '0 || wr_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got rd=%0d wr=%0d expected 0/0", rd_cnt, wr_cnt); end
        end
        rst = 1'b1;
        drive_cycle(1'b1, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
        checks++;
        if (rd_cnt !== 4'd1) begin errors++; $display("FAIL reset_first_read_cnt: got %0d expected 1", rd_cnt); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    endtask

    task automatic test_full_word();
        drive_cycle(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_write_rdata: got %h expected %h", data_sram_rdata, 32'hDEAD_BEEF); end
        checks++;
        if (wr_cnt !== 4'd1) begin errors++; $display("FAIL full_write_cnt: got %0d expected 1", wr_cnt); end
        drive_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_read_rdata: got %h expected %h", data_sram_rdata, 32'hDEAD_BEEF); end
        checks++;
        if (rd_cnt !== exp_rd[CNT_W-1:0]) begin errors++; $display("FAIL full_read_cnt: got %0d expected %0d", rd_cnt, exp_rd); end
    endtask

    task automatic test_byte_merge();
        drive_cycle(1'b1, 4'hF,    32'h0000_0200, 32'h1122_3344, 1'b0);
        drive_cycle(1'b1, 4'b0010, 32'h0000_0201, 32'h0000_AA00, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL merge_write_first: got %h expected %h", data_sram_rdata, 32'h1122_AA44); end
        drive_cycle(1'b1, 4'b0000, 32'h0000_0200, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h1122_AA44) begin errors++; $display("FAIL merge_lane1: got %h expected %h", data_sram_rdata, 32'h1122_AA44); end
        drive_cycle(1'b1, 4'b1000, 32'h0000_0203, 32'h5500_0000, 1'b0);
        drive_cycle(1'b1, 4'b0000, 32'h0000_0200, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h5522_AA44) begin errors++; $display("FAIL merge_lane3: got %h expected %h", data_sram_rdata, 32'h5522_AA44); end
    endtask

    task automatic test_hold_back_to_back();
        int rd0, wr0;
        drive_cycle(1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h1) begin errors++; $display("FAIL b2b_write: got %h expected %h", data_sram_rdata, 32'h1); end
        drive_cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h1) begin errors++; $display("FAIL b2b_read: got %h expected %h", data_sram_rdata, 32'h1); end
        rd0 = exp_rd;
        wr0 = exp_wr;
        // Idle cycles with garbage on the don't-care inputs.
        repeat (2) begin
            drive_cycle(1'b0, 4'($urandom), $urandom | 32'h0001_0000, $urandom, 1'b0);
            checks++;
            if (data_sram_rdata !== 32'h1) begin errors++; $display("FAIL idle_hold: got %h expected %h", data_sram_rdata, 32'h1); end
            checks++;
            if (rd_cnt !== rd0[CNT_W-1:0] || wr_cnt !== wr0[CNT_W-1:0] || addr_err !== 1'b0) begin
                errors++; $display("FAIL idle_state: got rd=%0d wr=%0d err=%b expected rd=%0d wr=%0d err=0", rd_cnt, wr_cnt, addr_err, rd0, wr0);
            end
        end
    endtask

    task automatic test_out_of_range();
        drive_cycle(1'b1, 4'h0, 32'h0001_0000, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h0 || addr_err !== 1'b1) begin errors++; $display("FAIL oor_read: got rdata=%h err=%b expected 0/1", data_sram_rdata, addr_err); end
        checks++;
        if (err_addr !== 32'h0001_0000) begin errors++; $display("FAIL oor_err_addr: got %h expected %h", err_addr, 32'h0001_0000); end
        checks++;
        if (rd_cnt !== exp_rd[CNT_W-1:0]) begin errors++; $display("FAIL oor_rd_cnt: got %0d expected %0d", rd_cnt, exp_rd); end
        drive_cycle(1'b1, 4'hF, 32'h0002_0000, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (err_addr !== 32'h0001_0000) begin errors++; $display("FAIL oor_first_wins: got %h expected %h", err_addr, 32'h0001_0000); end
        checks++;
        if (wr_cnt !== exp_wr[CNT_W-1:0]) begin errors++; $display("FAIL oor_wr_cnt: got %0d expected %0d", wr_cnt, exp_wr); end
        // The bad write must not have aliased onto word 0.
        drive_cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'h1) begin errors++; $display("FAIL oor_no_alias: got %h expected %h", data_sram_rdata, 32'h1); end
        drive_cycle(1'b1, 4'h0, 32'h0003_0000, 32'h0, 1'b1);
        checks++;
        if (addr_err !== 1'b1 || err_addr !== 32'h0003_0000) begin errors++; $display("FAIL clr_with_err: got err=%b addr=%h expected 1/%h", addr_err, err_addr, 32'h0003_0000); end
        drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (addr_err !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL clr_alone: got err=%b addr=%h expected 0/0", addr_err, err_addr); end
        // Last word of the window is still in range.
        drive_cycle(1'b1, 4'hF, 32'h0000_FFFC, 32'h0BAD_F00D, 1'b0);
        checks++;
        if (addr_err !== 1'b0 || data_sram_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL top_word: got err=%b rdata=%h expected 0/%h", addr_err, data_sram_rdata, 32'h0BAD_F00D); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'h0000_1000 + 32'($urandom_range(0, 1023)) * 4;
            drive_cycle(1'b1, 4'hF, pool[i], $urandom, 1'b0);
        end
        for (int n = 0; n < 400; n++) begin
            bit          en, clr;
            logic [3:0]  wen;
            logic [31:0] addr;
            en   = ($urandom_range(0, 9) < 8);
            clr  = ($urandom_range(0, 19) == 0);
            wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            addr = ($urandom_range(0, 9) == 0) ? (32'($urandom) | 32'h0001_0000)
                                               : (pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)));
            drive_cycle(en, wen, addr, $urandom, clr);
            if (exp_known) begin
                checks++;
                if (data_sram_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, data_sram_rdata, exp_rdata); end
            end
            checks++;
            if (addr_err !== exp_err || err_addr !== exp_err_addr) begin
                errors++; $display("FAIL rand_err[%0d]: got %b/%h expected %b/%h", n, addr_err, err_addr, exp_err, exp_err_addr);
            end
            checks++;
            if (rd_cnt !== exp_rd[CNT_W-1:0] || wr_cnt !== exp_wr[CNT_W-1:0]) begin
                errors++; $display("FAIL rand_cnt[%0d]: got rd=%0d wr=%0d expected rd=%0d wr=%0d", n, rd_cnt, wr_cnt, exp_rd, exp_wr);
            end
        end
    endtask

    task automatic test_saturation_retention();
        drive_cycle(1'b1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D, 1'b0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 4'h0, 32'h0000_4000, 32'h0, 1'b0);
            checks++;
            if (rd_cnt !== exp_rd[CNT_W-1:0]) begin errors++; $display("FAIL sat_step[%0d]: got %0d expected %0d", i, rd_cnt, exp_rd); end
        end
        checks++;
        if (rd_cnt !== 4'hF) begin errors++; $display("FAIL sat_final: got %0d expected 15", rd_cnt); end
        // Reset mid-burst with a write pending: it must be dropped.
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0000_4000;
        data_sram_wdata = 32'h0BAD_BAD0;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rd_cnt !== '0 || wr_cnt !== '0 || data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL midreset_async: got rd=%0d wr=%0d rdata=%h expected 0/0/0", rd_cnt, wr_cnt, data_sram_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive_cycle(1'b1, 4'h0, 32'h0000_4000, 32'h0, 1'b0);
        checks++;
        if (data_sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL retention: got %h expected %h", data_sram_rdata, 32'hCAFE_F00D); end
        checks++;
        if (rd_cnt !== 4'd1 || wr_cnt !== 4'd0) begin errors++; $display("FAIL post_reset_cnt: got rd=%0d wr=%0d expected 1/0", rd_cnt, wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_merge();
        test_hold_back_to_back();
        test_out_of_range();
        test_random();
        test_saturation_retention();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
